// File: rtl/fp_pkg.sv
// Shared definitions for the FP adder operand path.
// Holds the exception encodings of the internal adder word and the default
// field widths from which the IEEE and internal word sizes are derived.
package fp_pkg;

  localparam int SIZE_MANTISSA        = 24;  // includes hidden bit
  localparam int SIZE_EXPONENT        = 8;
  localparam int SIZE_EXCEPTION_FIELD = 2;
  localparam int SIZE_IEEE            = SIZE_MANTISSA + SIZE_EXPONENT;
  localparam int SIZE                 = SIZE_IEEE + SIZE_EXCEPTION_FIELD;
  localparam int SIZE_FLUSH_CNT       = 16;

  typedef enum logic [1:0] {
    EXC_ZERO   = 2'b00,
    EXC_NORMAL = 2'b01,
    EXC_INF    = 2'b10,
    EXC_NAN    = 2'b11
  } exc_e;

endpackage

// File: rtl/fp_operand_formatter_if.sv
// Operand-pair handshake bus between the issuing stage, the formatter and
// the adder pipeline.
//   in_valid/in_ready   : operand pair (sub_i, a_ieee_i, b_ieee_i) transfer
//   out_valid/out_ready : formatted pair (sub_o, a_number_o, b_number_o)
// master = the side that feeds operands and consumes formatted pairs,
// slave  = the formatter itself.
interface fp_operand_formatter_if #(
  parameter int size_ieee = fp_pkg::SIZE_IEEE,
  parameter int size      = fp_pkg::SIZE
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 sub_i;
  logic [size_ieee-1:0] a_ieee_i;
  logic [size_ieee-1:0] b_ieee_i;
  logic                 out_valid;
  logic                 out_ready;
  logic                 sub_o;
  logic [size-1:0]      a_number_o;
  logic [size-1:0]      b_number_o;

  modport master (
    output in_valid, sub_i, a_ieee_i, b_ieee_i, out_ready,
    input  in_ready, out_valid, sub_o, a_number_o, b_number_o
  );

  modport slave (
    input  in_valid, sub_i, a_ieee_i, b_ieee_i, out_ready,
    output in_ready, out_valid, sub_o, a_number_o, b_number_o
  );
endinterface

// File: rtl/fp_classify.sv
// Combinational classifier for one IEEE binary32-style operand.
// Ports:
//   ieee_i    : IEEE word {sign, exponent, fraction}
//   number_o  : internal word {exception, sign, exponent, fraction}
//   flushed_o : operand was a denormal and has been flushed to signed zero
module fp_classify
  import fp_pkg::*;
#(
  parameter int size_mantissa        = SIZE_MANTISSA,
  parameter int size_exponent        = SIZE_EXPONENT,
  parameter int size_exception_field = SIZE_EXCEPTION_FIELD
) (
  input  logic [size_mantissa+size_exponent-1:0]                      ieee_i,
  output logic [size_mantissa+size_exponent+size_exception_field-1:0] number_o,
  output logic                                                         flushed_o
);
  localparam int size_ieee = size_mantissa + size_exponent;

  logic                     sign;
  logic [size_exponent-1:0] expo;
  logic [size_mantissa-2:0] frac;

  assign sign = ieee_i[size_ieee-1];
  assign expo = ieee_i[size_ieee-2 -: size_exponent];
  assign frac = ieee_i[size_mantissa-2:0];

  always_comb begin
    number_o  = '0;
    flushed_o = 1'b0;
    if (expo == '0) begin
      // zero and denormal both leave as signed zero; only denormals count
      number_o  = {size_exception_field'(EXC_ZERO), sign, {(size_ieee-1){1'b0}}};
      flushed_o = |frac;
    end else if (&expo) begin
      if (frac == '0)
        number_o = {size_exception_field'(EXC_INF), sign, expo, {(size_mantissa-1){1'b0}}};
      else
        number_o = {size_exception_field'(EXC_NAN), ieee_i};  // payload kept
    end else begin
      number_o = {size_exception_field'(EXC_NORMAL), ieee_i};
    end
  end
endmodule

// File: rtl/fp_operand_formatter.sv
// Operand formatter in front of the dual-path FP adder/subtractor.
// Classifies operands A and B, flushes denormals, and presents the pair in
// internal format through a registered output with a one-entry skid so the
// adder can stall without losing pairs.
// Ports:
//   clk, rst       : clock, synchronous active-low reset
//   bus (slave)    : input pair handshake and formatted-pair handshake
//   flush_cnt_clr  : synchronous clear of the flush counter (beats increment)
//   flush_cnt_o    : saturating count of flushed denormal operands
module fp_operand_formatter
  import fp_pkg::*;
#(
  parameter int size_mantissa        = SIZE_MANTISSA,
  parameter int size_exponent        = SIZE_EXPONENT,
  parameter int size_exception_field = SIZE_EXCEPTION_FIELD,
  parameter int size_flush_cnt       = SIZE_FLUSH_CNT
) (
  input  logic                      clk,
  input  logic                      rst,
  fp_operand_formatter_if.slave     bus,
  input  logic                      flush_cnt_clr,
  output logic [size_flush_cnt-1:0] flush_cnt_o
);
  localparam int size_ieee = size_mantissa + size_exponent;
  localparam int size      = size_ieee + size_exception_field;
  localparam int NUM_OPS   = 2;

  typedef struct packed {
    logic            sub;
    logic [size-1:0] a;
    logic [size-1:0] b;
  } pair_t;

  logic [NUM_OPS-1:0][size_ieee-1:0] ieee;
  logic [NUM_OPS-1:0][size-1:0]      number;
  logic [NUM_OPS-1:0]                flushed;

  assign ieee[0] = bus.a_ieee_i;
  assign ieee[1] = bus.b_ieee_i;

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    fp_classify #(
      .size_mantissa       (size_mantissa),
      .size_exponent       (size_exponent),
      .size_exception_field(size_exception_field)
    ) u_classify (
      .ieee_i   (ieee[i]),
      .number_o (number[i]),
      .flushed_o(flushed[i])
    );
  end

  pair_t fmt, main_q, skid_q;
  logic  out_valid_q, skid_valid_q;
  logic  in_ready, fire_in, fire_out;

  assign fmt      = '{sub: bus.sub_i, a: number[0], b: number[1]};
  // in_ready depends only on the skid flag, so out_ready never reaches it
  assign in_ready = ~skid_valid_q;
  assign fire_in  = bus.in_valid & in_ready;
  assign fire_out = out_valid_q & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (skid_valid_q && bus.out_ready) begin
      main_q       <= skid_q;
      skid_valid_q <= 1'b0;
    end else if (fire_in && (!out_valid_q || bus.out_ready)) begin
      main_q      <= fmt;
      out_valid_q <= 1'b1;
    end else if (fire_in) begin
      // main is stalled: park the new pair behind it
      skid_q       <= fmt;
      skid_valid_q <= 1'b1;
    end else if (fire_out) begin
      out_valid_q <= 1'b0;
    end
  end

  // flush counter: 0..2 per accepted pair, sticks at all-ones
  logic [size_flush_cnt-1:0] flush_cnt_q;
  logic [1:0]                n_flush;
  logic [size_flush_cnt:0]   cnt_sum;

  assign n_flush = {1'b0, flushed[0]} + {1'b0, flushed[1]};
  assign cnt_sum = {1'b0, flush_cnt_q} + {{(size_flush_cnt-1){1'b0}}, n_flush};

  always_ff @(posedge clk) begin
    if (!rst)
      flush_cnt_q <= '0;
    else if (flush_cnt_clr)
      flush_cnt_q <= '0;
    else if (fire_in)
      flush_cnt_q <= cnt_sum[size_flush_cnt] ? '1 : cnt_sum[size_flush_cnt-1:0];
  end

  assign flush_cnt_o    = flush_cnt_q;
  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.sub_o      = main_q.sub;
  assign bus.a_number_o = main_q.a;
  assign bus.b_number_o = main_q.b;
endmodule

// File: tb/tb_fp_operand_formatter.sv
// Scoreboard bench for fp_operand_formatter: the driver pushes the reference
// result of every accepted pair; the monitor pops and compares on each
// output transfer and checks that stalled outputs hold steady.
module tb_fp_operand_formatter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_cnt_clr = 1'b0;
  logic [15:0] flush_cnt_o;

  always #5 clk = ~clk;

  fp_operand_formatter_if bus ();

  fp_operand_formatter dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .flush_cnt_clr(flush_cnt_clr),
    .flush_cnt_o  (flush_cnt_o)
  );

  typedef struct packed {
    logic        sub;
    logic [33:0] a;
    logic [33:0] b;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_cnt = 0;
  bit   last_fire;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference formatting: {flushed, exception, sign, exponent, fraction}
  function automatic logic [34:0] model(input logic [31:0] x);
    int   e;
    int   f;
    logic s;
    e = int'(x[30:23]);
    f = int'(x[22:0]);
    s = x[31];
    if (e == 0)   return {(f != 0), 2'b00, s, 31'b0};
    if (e == 255) return (f == 0) ? {1'b0, 2'b10, s, 8'hFF, 23'b0} : {1'b0, 2'b11, x};
    return {1'b0, 2'b01, x};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0]  e;
    logic [22:0] f;
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0:       e = 8'd0;
      1:       e = 8'hFF;
      default: e = 8'($urandom_range(1, 254));
    endcase
    f = ($urandom_range(0, 3) == 0) ? 23'd0 : r[22:0];
    return {r[31], e, f};
  endfunction

  // One clock of stimulus: drive after the falling edge, then check the
  // state left by the previous rising edge and predict the next one.
  task automatic cycle(input bit iv, input bit sb, input logic [31:0] a, input logic [31:0] b,
                       input bit ordy, input bit clr, input bit rstn);
    logic [34:0] ma, mb;
    int          n;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.sub_i     = sb;
    bus.a_ieee_i  = a;
    bus.b_ieee_i  = b;
    bus.out_ready = ordy;
    flush_cnt_clr = clr;
    rst           = rstn;
    #1;
    chk("in_ready", 72'(bus.in_ready), 72'(q.size() < 2));
    chk("out_valid", 72'(bus.out_valid), 72'(q.size() > 0));
    chk("flush_cnt", 72'(flush_cnt_o), 72'(exp_cnt));
    last_fire = rstn && iv && (q.size() < 2);
    if (!rstn) begin
      q.delete();
      exp_cnt = 0;
    end else begin
      n = 0;
      if (last_fire) begin
        ma = model(a);
        mb = model(b);
        q.push_back({sb, ma[33:0], mb[33:0]});
        n = int'(ma[34]) + int'(mb[34]);
      end
      if (clr) exp_cnt = 0;
      else if (last_fire) exp_cnt = (exp_cnt + n > 65535) ? 65535 : exp_cnt + n;
    end
  endtask

  task automatic idle(input bit ordy);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, ordy, 1'b0, 1'b1);
  endtask

  // Monitor: compares on each output transfer, checks hold during stalls
  initial begin : monitor
    exp_t held;
    exp_t e;
    bit   hold_pend;
    hold_pend = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      #2;
      if (hold_pend) begin
        chk("stall_valid", 72'(bus.out_valid), 72'd1);
        chk("stall_data", 72'({bus.sub_o, bus.a_number_o, bus.b_number_o}), 72'(held));
      end
      if (rst && bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("sb_underflow", 72'(bus.out_valid), 72'd0);
        end else begin
          e = q.pop_front();
          chk("sb_sub", 72'(bus.sub_o), 72'(e.sub));
          chk("sb_a", 72'(bus.a_number_o), 72'(e.a));
          chk("sb_b", 72'(bus.b_number_o), 72'(e.b));
        end
      end
      hold_pend = rst && bus.out_valid && !bus.out_ready;
      held      = {bus.sub_o, bus.a_number_o, bus.b_number_o};
    end
  end

  initial begin : driver
    int accepted;
    int budget;
    bus.in_valid  = 1'b0;
    bus.sub_i     = 1'b0;
    bus.a_ieee_i  = '0;
    bus.b_ieee_i  = '0;
    bus.out_ready = 1'b0;

    // reset state
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("rst_a", 72'(bus.a_number_o), 72'd0);
    chk("rst_b", 72'(bus.b_number_o), 72'd0);
    chk("rst_sub", 72'(bus.sub_o), 72'd0);

    // normal operands, one-cycle latency
    cycle(1'b1, 1'b0, 32'h3F800000, 32'hC0000000, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("norm_valid", 72'(bus.out_valid), 72'd1);
    chk("norm_a", 72'(bus.a_number_o), 72'h13F800000);
    chk("norm_b", 72'(bus.b_number_o), 72'h1C0000000);
    chk("norm_sub", 72'(bus.sub_o), 72'd0);

    // signed zero, infinity, NaN
    cycle(1'b1, 1'b0, 32'h80000000, 32'h7F800000, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("spec_a", 72'(bus.a_number_o), 72'h080000000);
    chk("spec_b", 72'(bus.b_number_o), 72'h27F800000);
    cycle(1'b1, 1'b1, 32'h7FC00001, 32'h3F800000, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("nan_a", 72'(bus.a_number_o), 72'h37FC00001);
    chk("nan_sub", 72'(bus.sub_o), 72'd1);

    // denormal flush and counter; clear beats a simultaneous increment
    cycle(1'b1, 1'b0, 32'h00000001, 32'h80400000, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("den_a", 72'(bus.a_number_o), 72'h000000000);
    chk("den_b", 72'(bus.b_number_o), 72'h080000000);
    chk("den_cnt", 72'(flush_cnt_o), 72'd2);
    cycle(1'b1, 1'b0, 32'h00000001, 32'h00000002, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    chk("clr_cnt", 72'(flush_cnt_o), 72'd0);

    // back-pressure: three back-to-back pairs against a stalled consumer
    cycle(1'b1, 1'b0, 32'h3F800001, 32'h40000001, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 32'h3F800002, 32'h40000002, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'h3F800003, 32'h40000003, 1'b0, 1'b0, 1'b1);
    chk("bp_in_ready", 72'(bus.in_ready), 72'd0);
    chk("bp_third_held", 72'(last_fire), 72'd0);
    cycle(1'b1, 1'b0, 32'h3F800003, 32'h40000003, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'h3F800003, 32'h40000003, 1'b1, 1'b0, 1'b1);
    chk("bp_ready_back", 72'(bus.in_ready), 72'd1);
    chk("bp_third_fire", 72'(last_fire), 72'd1);
    repeat (4) idle(1'b1);
    chk("bp_drain", 72'(q.size()), 72'd0);

    // random traffic with random stalls
    accepted = 0;
    budget   = 20000;
    while (accepted < 1000 && budget > 0) begin
      cycle(($urandom_range(0, 9) < 7), 1'($urandom), rnd_op(), rnd_op(),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0), 1'b1);
      if (last_fire) accepted++;
      budget--;
    end
    chk("rand_accepted", 72'(accepted), 72'd1000);
    repeat (4) idle(1'b1);
    chk("rand_drain", 72'(q.size()), 72'd0);

    // counter saturation
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    repeat (32767) cycle(1'b1, 1'b0, 32'h00000001, 32'h80000001, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("sat_pre", 72'(flush_cnt_o), 72'd65534);
    cycle(1'b1, 1'b0, 32'h00000001, 32'h80000001, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("sat_hit", 72'(flush_cnt_o), 72'hFFFF);
    cycle(1'b1, 1'b0, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("sat_hold", 72'(flush_cnt_o), 72'hFFFF);
    repeat (2) idle(1'b1);

    // reset with both entries full
    cycle(1'b1, 1'b1, 32'h00000005, 32'h3F800005, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'h40000006, 32'h00000006, 1'b0, 1'b0, 1'b1);
    chk("full_before_rst", 72'(bus.in_ready), 72'd1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("rstf_valid", 72'(bus.out_valid), 72'd0);
    chk("rstf_ready", 72'(bus.in_ready), 72'd1);
    chk("rstf_cnt", 72'(flush_cnt_o), 72'd0);
    chk("rstf_a", 72'(bus.a_number_o), 72'd0);
    repeat (4) idle(1'b1);
    chk("rstf_no_stale", 72'(bus.out_valid), 72'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
